// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating counters.
// Zero-latency lookup for fetch, single resolve/update port from EX.
module branch_predictor #(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 16
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] if_pc,
  output logic                  pred_taken,
  output logic [DATA_WIDTH-1:0] pred_target,
  input  logic                  update_en,
  input  logic [DATA_WIDTH-1:0] update_pc,
  input  logic                  update_taken,
  input  logic [DATA_WIDTH-1:0] update_target,
  input  logic                  ex_pred_taken,
  input  logic [DATA_WIDTH-1:0] ex_pred_target,
  output logic                  mispredict,
  output logic [DATA_WIDTH-1:0] redirect_pc
);

  localparam int IDX = $clog2(NUM_ENTRIES);
  localparam int TW  = DATA_WIDTH - IDX - 2;

  logic [NUM_ENTRIES-1:0] valid_q, valid_d;
  logic [TW-1:0]          tag_q [NUM_ENTRIES];
  logic [TW-1:0]          tag_d [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  tgt_q [NUM_ENTRIES];
  logic [DATA_WIDTH-1:0]  tgt_d [NUM_ENTRIES];
  logic [1:0]             cnt_q [NUM_ENTRIES];
  logic [1:0]             cnt_d [NUM_ENTRIES];

  logic [IDX-1:0] if_idx, up_idx;
  logic [TW-1:0]  if_tag, up_tag;
  logic           if_hit, up_hit;
  logic           unused_pc_bits;

  assign if_idx = if_pc[IDX+1:2];
  assign if_tag = if_pc[DATA_WIDTH-1:IDX+2];
  assign up_idx = update_pc[IDX+1:2];
  assign up_tag = update_pc[DATA_WIDTH-1:IDX+2];

  assign unused_pc_bits = ^{if_pc[1:0], update_pc[1:0]};

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  always_comb begin
    pred_taken  = 1'b0;
    pred_target = '0;
    if (rstn && if_hit && cnt_q[if_idx][1]) begin
      pred_taken  = 1'b1;
      pred_target = tgt_q[if_idx];
    end
  end

  always_comb begin
    mispredict  = 1'b0;
    redirect_pc = update_pc + DATA_WIDTH'(4);
    if (update_taken) redirect_pc = update_target;
    if (rstn && update_en) begin
      mispredict = (ex_pred_taken != update_taken) ||
                   (update_taken && (ex_pred_target != update_target));
    end
  end

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    tgt_d   = tgt_q;
    cnt_d   = cnt_q;
    if (update_en) begin
      if (up_hit) begin
        if (update_taken) begin
          tgt_d[up_idx] = update_target;
          if (cnt_q[up_idx] != 2'b11) cnt_d[up_idx] = cnt_q[up_idx] + 2'd1;
        end else if (cnt_q[up_idx] != 2'b00) begin
          cnt_d[up_idx] = cnt_q[up_idx] - 2'd1;
        end
      end else if (update_taken) begin
        // Allocation starts weakly-taken so one not-taken flips it.
        valid_d[up_idx] = 1'b1;
        tag_d[up_idx]   = up_tag;
        tgt_d[up_idx]   = update_target;
        cnt_d[up_idx]   = 2'b10;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      valid_q <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        cnt_q[i] <= 2'b01;
      end
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      tgt_q   <= tgt_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: doc/branch_predictor.md
BRANCH_PREDICTOR -- requirements
Module: branch_predictor

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of PC, target and redirect values.
REQ-002 Parameter NUM_ENTRIES, default 16, power of two >= 2: number of predictor table entries; IDX = log2(NUM_ENTRIES).
REQ-003 clk  input  1  single clock; all state updates occur on the rising edge.
REQ-004 rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 if_pc  input  DATA_WIDTH  fetch-stage PC to predict for.
REQ-006 pred_taken  output  1  prediction for if_pc; 1 = taken.
REQ-007 pred_target  output  DATA_WIDTH  predicted target; 0 when pred_taken = 0.
REQ-008 update_en  input  1  an executed conditional branch is resolving in EX this cycle.
REQ-009 update_pc  input  DATA_WIDTH  PC of the resolving branch.
REQ-010 update_taken  input  1  resolved outcome, driven by the branch_control taken output.
REQ-011 update_target  input  DATA_WIDTH  computed branch target of the resolving branch.
REQ-012 ex_pred_taken  input  1  prediction carried down the pipeline with the resolving branch.
REQ-013 ex_pred_target  input  DATA_WIDTH  predicted target carried with the resolving branch.
REQ-014 mispredict  output  1  pipeline flush request for IF/ID.
REQ-015 redirect_pc  output  DATA_WIDTH  correct next PC after a misprediction.

Function
REQ-016 Table entry SHALL hold valid (1b), tag (DATA_WIDTH-IDX-2 bits), target (DATA_WIDTH), counter (2b).
REQ-017 Index SHALL be pc[IDX+1:2]; tag SHALL be pc[DATA_WIDTH-1:IDX+2]; pc[1:0] ignored.
REQ-018 Lookup SHALL be combinational, zero latency: hit = valid & tag match for if_pc's entry.
REQ-019 pred_taken SHALL be hit & counter[1]; pred_target SHALL be the entry target when pred_taken = 1, else 0.
REQ-020 Counter states: 00 strongly-NT, 01 weakly-NT, 10 weakly-T, 11 strongly-T.
REQ-021 On a clock edge with update_en = 1 and hit for update_pc: counter SHALL increment if update_taken = 1 (saturate at 11), else decrement (saturate at 00).
REQ-022 On hit with update_taken = 1, the entry target SHALL be overwritten with update_target.
REQ-023 On miss with update_taken = 1: entry SHALL be allocated/replaced: valid = 1, tag and target from update, counter = 10.
REQ-024 On miss with update_taken = 0: table SHALL be unchanged.
REQ-025 update_en = 0: table SHALL be unchanged.
REQ-026 Lookup and update to the same index in the same cycle: lookup SHALL return the pre-edge contents (no bypass); the update SHALL take effect from the next cycle.
REQ-027 mispredict SHALL be combinational: update_en & ((ex_pred_taken != update_taken) | (update_taken & ex_pred_target != update_target)).
REQ-028 redirect_pc SHALL be update_target when update_taken = 1, else update_pc + 4 (modulo 2^DATA_WIDTH); value don't-care when mispredict = 0.
REQ-029 Only one update per cycle; no internal stall or back-pressure; block is always ready.

Reset
REQ-030 rstn = 0 SHALL immediately clear all valid bits, set all counters to 01 and all targets to 0, independent of clk.
REQ-031 While rstn = 0: pred_taken = 0, pred_target = 0; updates SHALL be ignored.
REQ-032 Reset during an update cycle SHALL discard that update; first update honoured is on the first rising edge with rstn = 1.

Verification
REQ-033 Reset then lookup if_pc = 0x100 -> pred_taken = 0, pred_target = 0.
REQ-034 Update pc 0x100, taken, target 0x80, ex_pred_taken = 0 -> mispredict = 1, redirect_pc = 0x80; next cycle lookup 0x100 -> pred_taken = 1, pred_target = 0x80 (counter 10).
REQ-035 Three further not-taken updates for 0x100 -> counter 01, 00, 00 (saturates); pred_taken = 0 after the first; not-taken update with ex_pred_taken = 1 -> redirect_pc = 0x104.
REQ-036 Alias: allocate 0x100, then taken update for 0x140 (same index, NUM_ENTRIES = 16) -> lookup 0x100 misses, 0x140 hits with its own target.
REQ-037 Lookup and update of 0x200 in the same cycle -> lookup shows old value, new value visible next cycle.
REQ-038 Assert rstn low mid-sequence between edges -> all outputs and table cleared immediately; pending update not applied.
